// File: rtl/afpm_io_sequencer.sv
// Byte-serial operand loader and result unloader for the 16-bit
// logarithmic floating-point multiplier core.
module afpm_io_sequencer #(
    parameter int                BYTE_W  = 8,
    parameter int                DATA_W  = 2 * BYTE_W,
    parameter int                TIMEOUT = 15,
    parameter logic [DATA_W-1:0] NAN_VAL = 16'h7E00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] a_byte,
    input  logic [BYTE_W-1:0] b_byte,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              mul_start,
    input  logic              mul_valid,
    input  logic [DATA_W-1:0] mul_result,
    output logic [BYTE_W-1:0] res_byte,
    output logic              res_valid,
    output logic              res_last,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LOAD_LO,
        S_LOAD_HI,
        S_ISSUE,
        S_WAIT,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    localparam logic [7:0] LP_CNT_MAX = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_result;
    logic [7:0]        r_cnt;
    logic              r_mul_start;
    logic [BYTE_W-1:0] r_res_byte;
    logic              r_res_valid;
    logic              r_res_last;
    logic              r_busy;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD_LO;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_mul_start <= 1'b0;
            r_res_byte  <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else if (ena) begin
            r_mul_start <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            unique case (r_state)
                S_LOAD_LO: begin
                    if (in_valid) begin
                        r_op_a[BYTE_W-1:0] <= a_byte;
                        r_op_b[BYTE_W-1:0] <= b_byte;
                        r_state            <= S_LOAD_HI;
                        r_busy             <= 1'b1;
                    end
                end
                S_LOAD_HI: begin
                    if (in_valid) begin
                        r_op_a[DATA_W-1:BYTE_W] <= a_byte;
                        r_op_b[DATA_W-1:BYTE_W] <= b_byte;
                        r_state                 <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mul_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // a result landing on the expiry cycle beats the timeout
                    if (mul_valid) begin
                        r_result <= mul_result;
                        r_state  <= S_OUT_LO;
                    end else if (r_cnt == LP_CNT_MAX) begin
                        r_result <= NAN_VAL;
                        r_err    <= 1'b1;
                        r_state  <= S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    r_res_byte  <= r_result[BYTE_W-1:0];
                    r_res_valid <= 1'b1;
                    r_state     <= S_OUT_HI;
                end
                S_OUT_HI: begin
                    r_res_byte  <= r_result[DATA_W-1:BYTE_W];
                    r_res_valid <= 1'b1;
                    r_res_last  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_LOAD_LO;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_LOAD_LO;
                end
            endcase
        end
    end

    // strobes are masked while frozen so a held pulse is not seen twice
    assign mul_start = r_mul_start & ena;
    assign res_valid = r_res_valid & ena;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign res_byte  = r_res_byte;
    assign res_last  = r_res_last;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_afpm_io_sequencer.sv
// Scoreboard bench for afpm_io_sequencer: directed operations with a
// hand-driven multiplier stub.
module tb_afpm_io_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a_byte = '0;
    logic [7:0]  b_byte = '0;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mul_start;
    logic        mul_valid = 1'b0;
    logic [15:0] mul_result = '0;
    logic [7:0]  res_byte;
    logic        res_valid;
    logic        res_last;
    logic        busy;
    logic        err;

    afpm_io_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .a_byte     (a_byte),
        .b_byte     (b_byte),
        .op_a       (op_a),
        .op_b       (op_b),
        .mul_start  (mul_start),
        .mul_valid  (mul_valid),
        .mul_result (mul_result),
        .res_byte   (res_byte),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t q[$];
    chk_t cq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_start = 0;
    int   n_rv = 0;
    int   n_byte = 0;

    // monitor: the only process that judges and counts
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        if (mul_start) n_start++;
        if (res_valid) n_rv++;
        if (!ena && rst_n) begin
            n_chk++;
            if (res_valid || mul_start)
                $display("FAIL freeze_strobe actual=%b%b required=00",
                         res_valid, mul_start);
            else
                n_pass++;
        end
        if (res_valid) begin
            n_chk++;
            n_byte++;
            if (q.size() == 0) begin
                $display("FAIL res_unexpected actual=%h/%b required=none",
                         res_byte, res_last);
            end else begin
                e = q.pop_front();
                if (res_byte === e.b && res_last === e.l)
                    n_pass++;
                else
                    $display("FAIL res_byte[%0d] actual=%h/%b required=%h/%b",
                             n_byte, res_byte, res_last, e.b, e.l);
            end
        end
        while (cq.size() > 0) begin
            c = cq.pop_front();
            n_chk++;
            if (c.act === c.exp)
                n_pass++;
            else
                $display("FAIL %s actual=%h required=%h", c.nm, c.act, c.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        chk_t c;
        c.nm  = nm;
        c.act = act;
        c.exp = exp;
        cq.push_back(c);
    endtask

    task automatic expect_res(input logic [15:0] r);
        q.push_back({r[7:0], 1'b0});
        q.push_back({r[15:8], 1'b1});
    endtask

    task automatic send(input logic [7:0] alo, input logic [7:0] blo,
                        input logic [7:0] ahi, input logic [7:0] bhi,
                        input int gap);
        in_valid = 1'b1;
        a_byte   = alo;
        b_byte   = blo;
        tick();
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            a_byte   = 8'hAA;
            b_byte   = 8'h55;
            tick();
        end
        in_valid = 1'b1;
        a_byte   = ahi;
        b_byte   = bhi;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mul_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) push("start_timeout", 0, 1);
    endtask

    task automatic stub(input logic [15:0] r);
        mul_valid  = 1'b1;
        mul_result = r;
        tick();
        mul_valid  = 1'b0;
        mul_result = 16'h0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        tick();
        push("drain_left", q.size(), 0);
    endtask

    task automatic check_reset_vals(input string nm);
        push({nm, "_ops"}, {op_a, op_b}, 0);
        push({nm, "_outs"},
             {26'd0, res_byte == 8'd0, res_valid, res_last, busy, err,
              mul_start},
             {26'd0, 1'b1, 5'd0});
    endtask

    initial begin
        int s0;
        int k;
        int rv0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // nominal, plus latency from high-byte accept to low result byte
        s0 = n_start;
        expect_res(16'h4480);
        send(8'h00, 8'h00, 8'h3E, 8'h42, 0);
        wait_start();
        push("nom_op_a", op_a, 16'h3E00);
        push("nom_op_b", op_b, 16'h4200);
        tick();
        stub(16'h4480);
        k = 0;
        while (!res_valid && k < 10) begin
            tick();
            k++;
        end
        push("nom_latency", 3 + k, 4);
        drain();
        push("nom_busy", busy, 0);
        push("nom_starts", n_start - s0, 1);
        push("nom_err", err, 0);

        // gaps between bytes and junk during WAIT
        s0 = n_start;
        expect_res(16'h4480);
        send(8'h00, 8'h00, 8'h3E, 8'h42, 3);
        wait_start();
        push("gap_op_a", op_a, 16'h3E00);
        push("gap_op_b", op_b, 16'h4200);
        in_valid = 1'b1;
        a_byte   = 8'hFF;
        b_byte   = 8'hEE;
        tick();
        stub(16'h4480);
        in_valid = 1'b0;
        drain();
        push("gap_op_a_held", op_a, 16'h3E00);
        push("gap_op_b_held", op_b, 16'h4200);
        push("gap_starts", n_start - s0, 1);

        // result arrives on the expiry cycle
        expect_res(16'h3C00);
        send(8'h11, 8'h22, 8'h33, 8'h44, 0);
        wait_start();
        push("race_op_a", op_a, 16'h3311);
        push("race_op_b", op_b, 16'h4422);
        repeat (14) tick();
        stub(16'h3C00);
        drain();
        push("race_err", err, 0);

        // freeze during WAIT and during OUT_LO
        expect_res(16'hABCD);
        send(8'h01, 8'h02, 8'h03, 8'h04, 0);
        wait_start();
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        stub(16'hABCD);
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        drain();
        push("frz_op_a", op_a, 16'h0301);
        push("frz_busy", busy, 0);

        // timeout substitutes NaN and sets err
        expect_res(16'h7E00);
        send(8'h05, 8'h06, 8'h07, 8'h08, 0);
        wait_start();
        k = 0;
        while (!res_valid && k < 40) begin
            tick();
            k++;
        end
        push("tmo_latency", k, 16);
        drain();
        push("tmo_err", err, 1);

        // err survives a following good operation
        expect_res(16'h4000);
        send(8'h00, 8'h00, 8'h00, 8'h40, 0);
        wait_start();
        tick();
        stub(16'h4000);
        drain();
        push("sticky_err", err, 1);

        // reset mid-WAIT, then a late result that must be ignored
        send(8'h09, 8'h0A, 8'h0B, 8'h0C, 0);
        wait_start();
        tick();
        rv0 = n_rv;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        rst_n = 1'b1;
        tick();
        stub(16'h1111);
        repeat (8) tick();
        push("rst_no_output", n_rv - rv0, 0);
        push("rst_busy", busy, 0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
